reg_alu_exec_unit: RTL and testbench
====================================

Name: reg_alu_exec_unit

Overview:
- Parametrised successor to the fixed 16x32 register-bank/ALU top.
- Holds a 2^REG_ADDR_W x DATA_W register file. Executes one three-operand ALU instruction (rd <- rs OP rt) per start/done handshake, through a 4-state sequencer.
- Exposes a registered debug display port that reads any register slice independently of execution.
- Sits between the instruction-entry/DFT front end and the board display.

Parameters:
- DATA_W, 32, operand/register width; power of two, >= 16, multiple of DISP_W.
- REG_ADDR_W, 5, register address width; register count = 2^REG_ADDR_W.
- DISP_W, 16, display slice width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  4  ALU operation code.
- rs  in  REG_ADDR_W  source A address.
- rt  in  REG_ADDR_W  source B / shift-amount address.
- rd  in  REG_ADDR_W  destination address.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal op flag; valid with done, held until the next accepted start.
- flag_z  out  1  result zero (FLAGS_EN).
- flag_n  out  1  result MSB (FLAGS_EN).
- flag_v  out  1  signed overflow (FLAGS_EN).
- dbg_addr  in  REG_ADDR_W  display register address.
- disp_sel  in  max(1,log2(DATA_W/DISP_W))  display slice index; 0 = bits [DISP_W-1:0].
- display_output  out  DISP_W  registered display data.

Behaviour:
- Reset (async, rst=1):
  - All registers cleared to 0; state = IDLE.
  - busy, done, err, flag_z, flag_n, flag_v and display_output all = 0.
  - Reset during READ, EXEC or WB aborts the operation: no write and no done.
- Register 0 always reads 0. Writes to address 0 are discarded silently; done still pulses and err = 0.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed A<B -> 1, else 0).
  - 10-15 illegal.
- Arithmetic is modulo 2^DATA_W.
- Shift amount is B[log2(DATA_W)-1:0]; upper bits of B are ignored. SRA replicates A's MSB.
- State machine:
  - IDLE: if start=1, latch op/rs/rt/rd -> READ. Otherwise stay.
  - READ: capture A=reg[rs], B=reg[rt] -> EXEC.
  - EXEC: compute result into a result register; illegal op sets a pending-err flag -> WB.
  - WB: write reg[rd] unless illegal or rd=0. Assert done=1 for this cycle; err updated -> IDLE.
- Timing:
  - Start accepted at edge N -> done high during cycle N+3.
  - The written value is readable by an instruction started at edge N+4 or later.
  - Back-to-back throughput: one instruction per 4 cycles.
- start while busy or in WB is ignored, not queued.
- op/rs/rt/rd may change freely after acceptance.
- Display:
  - display_output <= reg[dbg_addr][disp_sel*DISP_W +: DISP_W] every cycle; 1-cycle latency.
  - A same-cycle WB write to dbg_addr shows the old value first and the new value next cycle.
  - Out-of-range disp_sel returns 0.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined:
  - flag_z, flag_n and flag_v are registered in WB for every legal op, including rd=0.
  - flag_v is set only for ADD/SUB signed overflow; it is 0 for all other ops.
  - Flags hold their previous value on an illegal op.
- Undefined: flag_z, flag_n and flag_v are tied to 0 and no flag logic is synthesised.

Test Plan:
- Reset, then read all registers via dbg_addr -> display_output=0x0000 for every register and slice; busy=0.
- Preload r1=0x7FFFFFFF and r2=1 via ADD from r0 paths; ADD rd=3 -> after 4 cycles r3=0x80000000, done pulses once at N+3; with ALU_FLAGS_EN, flag_v=1 and flag_n=1.
- r4=0xF0000000, r5=4; SRA rd=6 -> r6=0xFF000000. SRL -> 0x0F000000. r5=36 with SLL -> shift by 4 (DATA_W=32).
- ADD rd=0 -> r0 still reads 0, done=1, err=0. op=12 -> no write, done=1, err=1 held until the next start.
- Second start pulsed during EXEC -> ignored: exactly one done, and the target of the second start is unchanged.
- rst asserted mid-EXEC -> busy=0 and done=0 immediately, rd not written, r-file cleared. disp_sel=1 on r6 after re-run -> display_output=0xFF00.

Source files
------------

// File: rtl/reg_alu_exec_unit.sv
// Register file plus 4-state ALU sequencer with a registered debug display.
// Optional result flags are built when ALU_FLAGS_EN is defined.
module reg_alu_exec_unit #(
  parameter  int DATA_W     = 32,
  parameter  int REG_ADDR_W = 5,
  parameter  int DISP_W     = 16,
  localparam int N_SLICE    = DATA_W / DISP_W,
  localparam int SEL_W      = (N_SLICE > 1) ? $clog2(N_SLICE) : 1,
  localparam int SH_W       = $clog2(DATA_W),
  localparam int NREG       = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_v,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [SEL_W-1:0]      disp_sel,
  output logic [DISP_W-1:0]     display_output
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;

  logic [1:0]            state;
  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     a_q;
  logic [DATA_W-1:0]     b_q;
  logic [DATA_W-1:0]     res_q;
  logic                  pend_err;
  logic [DATA_W-1:0]     rf [NREG];

  logic [DATA_W-1:0]     sum;
  logic [DATA_W-1:0]     diff;
  logic [SH_W-1:0]       shamt;
  logic                  slt;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_ill;
  logic [DATA_W-1:0]     dbg_word;

  assign sum   = a_q + b_q;
  assign diff  = a_q - b_q;
  assign shamt = b_q[SH_W-1:0];
  assign slt   = $signed(a_q) < $signed(b_q);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_SLL:  alu_res = a_q << shamt;
      OP_SRL:  alu_res = a_q >> shamt;
      OP_SRA:  alu_res = $signed(a_q) >>> shamt;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt};
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      pend_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (start) begin
            op_q  <= op;
            rs_q  <= rs;
            rt_q  <= rt;
            rd_q  <= rd;
            busy  <= 1'b1;
            err   <= 1'b0;
            state <= S_READ;
          end
        end
        (state == S_READ): begin
          a_q   <= rf[rs_q];
          b_q   <= rf[rt_q];
          state <= S_EXEC;
        end
        (state == S_EXEC): begin
          res_q    <= alu_res;
          pend_err <= alu_ill;
          state    <= S_WB;
        end
        (state == S_WB): begin
          done  <= 1'b1;
          busy  <= 1'b0;
          err   <= pend_err;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // r0 is never written, so it always reads back as its reset value of 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state == S_WB && !pend_err && rd_q != '0) begin
      rf[rd_q] <= res_q;
    end
  end

  assign dbg_word = rf[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_output <= '0;
    end else if (int'(disp_sel) < N_SLICE) begin
      display_output <= dbg_word[int'(disp_sel)*DISP_W +: DISP_W];
    end else begin
      display_output <= '0;
    end
  end

`ifdef ALU_FLAGS_EN
  logic alu_v;
  logic v_q;
  logic fz_q;
  logic fn_q;
  logic fv_q;

  always_comb begin
    alu_v = 1'b0;
    if (op_q == OP_ADD)
      alu_v = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
              (sum[DATA_W-1] != a_q[DATA_W-1]);
    else if (op_q == OP_SUB)
      alu_v = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
              (diff[DATA_W-1] != a_q[DATA_W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= 1'b0;
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      if (state == S_EXEC) v_q <= alu_v;
      if (state == S_WB && !pend_err) begin
        fz_q <= (res_q == '0);
        fn_q <= res_q[DATA_W-1];
        fv_q <= v_q;
      end
    end
  end

  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign flag_v = fv_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_reg_alu_exec_unit.sv
// Directed bench for reg_alu_exec_unit (default DATA_W=32, 32 registers).
// Flag expectations follow ALU_FLAGS_EN when the bench is built with it.
module tb_reg_alu_exec_unit;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] XOR = 4'd4;
  localparam logic [3:0] NOR = 4'd5;
  localparam logic [3:0] SLL = 4'd6;
  localparam logic [3:0] SRL = 4'd7;
  localparam logic [3:0] SRA = 4'd8;
  localparam logic [3:0] SLT = 4'd9;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        err;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic [4:0]  dbg_addr;
  logic [0:0]  disp_sel;
  logic [15:0] display_output;

  int          n_chk;
  int          n_fail;
  int          ndone;
  int          at;
  logic        err_d;
  logic [15:0] disp3;
  logic [15:0] disp4;
  logic [31:0] val;

  reg_alu_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs(rs), .rt(rt), .rd(rd),
    .busy(busy), .done(done), .err(err),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .dbg_addr(dbg_addr), .disp_sel(disp_sel),
    .display_output(display_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z,
                             input logic n, input logic v);
`ifdef ALU_FLAGS_EN
    check(tag, {29'd0, flag_z, flag_n, flag_v}, {29'd0, z, n, v});
`else
    check(tag, {29'd0, flag_z, flag_n, flag_v}, 32'd0 & {29'd0, z, n, v});
`endif
  endtask

  task automatic run(input logic [3:0] o, input logic [4:0] d,
                     input logic [4:0] s, input logic [4:0] t);
    @(negedge clk);
    op = o; rd = d; rs = s; rt = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = ~o; rd = ~d; rs = ~s; rt = ~t;
    check("busy_on", {31'd0, busy}, 32'd1);
    check("err_clr", {31'd0, err}, 32'd0);
    ndone = 0; at = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; at = k; end
      if (k == 3) begin err_d = err; disp3 = display_output; end
      if (k == 4) disp4 = display_output;
    end
    check("done_cnt", ndone, 1);
    check("done_at", at, 3);
    check("busy_off", {31'd0, busy}, 32'd0);
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    dbg_addr = a; disp_sel = 1'b0;
    @(negedge clk);
    v[15:0] = display_output;
    disp_sel = 1'b1;
    @(negedge clk);
    v[31:16] = display_output;
  endtask

  task automatic build();
    run(NOR, 5'd7, 5'd0, 5'd0);
    run(SUB, 5'd2, 5'd0, 5'd7);
    run(ADD, 5'd10, 5'd2, 5'd2);
    run(ADD, 5'd5, 5'd10, 5'd10);
    run(ADD, 5'd12, 5'd5, 5'd5);
    run(ADD, 5'd13, 5'd12, 5'd12);
    run(ADD, 5'd14, 5'd13, 5'd12);
    run(ADD, 5'd15, 5'd14, 5'd5);
    run(SLL, 5'd4, 5'd7, 5'd15);
    run(SRL, 5'd1, 5'd7, 5'd2);
    run(SRA, 5'd6, 5'd4, 5'd5);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0; rd = '0;
    dbg_addr = '0; disp_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_disp", {16'd0, display_output}, 32'd0);
    check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 32; r++) begin
      peek(5'(r), val);
      check("rst_reg", val, 32'd0);
    end

    run(NOR, 5'd7, 5'd0, 5'd0);
    run(SUB, 5'd2, 5'd0, 5'd7);
    run(SRL, 5'd1, 5'd7, 5'd2);
    peek(5'd1, val);
    check("r1_max", val, 32'h7FFF_FFFF);
    run(ADD, 5'd3, 5'd1, 5'd2);
    check_flags("add_ovf", 1'b0, 1'b1, 1'b1);
    peek(5'd3, val);
    check("r3_add", val, 32'h8000_0000);

    build();
    peek(5'd4, val);
    check("r4", val, 32'hF000_0000);
    peek(5'd5, val);
    check("r5", val, 32'd4);
    peek(5'd6, val);
    check("sra", val, 32'hFF00_0000);
    run(SRL, 5'd16, 5'd4, 5'd5);
    peek(5'd16, val);
    check("srl", val, 32'h0F00_0000);
    run(ADD, 5'd18, 5'd13, 5'd13);
    run(ADD, 5'd17, 5'd18, 5'd5);
    run(SLL, 5'd19, 5'd1, 5'd17);
    peek(5'd19, val);
    check("sll_wrap", val, 32'hFFFF_FFF0);
    run(AND, 5'd20, 5'd7, 5'd1);
    run(OR, 5'd21, 5'd4, 5'd5);
    run(XOR, 5'd22, 5'd7, 5'd4);
    run(SLT, 5'd23, 5'd4, 5'd2);
    check_flags("slt_flags", 1'b0, 1'b0, 1'b0);
    run(SLT, 5'd24, 5'd2, 5'd4);
    run(SUB, 5'd25, 5'd3, 5'd2);
    check_flags("sub_ovf", 1'b0, 1'b0, 1'b1);
    peek(5'd20, val); check("and", val, 32'h7FFF_FFFF);
    peek(5'd21, val); check("or", val, 32'hF000_0004);
    peek(5'd22, val); check("xor", val, 32'h0FFF_FFFF);
    peek(5'd23, val); check("slt_t", val, 32'd1);
    peek(5'd24, val); check("slt_f", val, 32'd0);
    peek(5'd25, val); check("sub", val, 32'h7FFF_FFFF);

    run(SUB, 5'd26, 5'd2, 5'd2);
    check_flags("zero", 1'b1, 1'b0, 1'b0);
    run(ADD, 5'd0, 5'd1, 5'd2);
    check("r0_err", {31'd0, err_d}, 32'd0);
    check_flags("r0_flags", 1'b0, 1'b1, 1'b1);
    peek(5'd0, val);
    check("r0_zero", val, 32'd0);

    run(4'd12, 5'd27, 5'd1, 5'd2);
    check("ill_err", {31'd0, err_d}, 32'd1);
    check_flags("ill_hold", 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("err_held", {31'd0, err}, 32'd1);
    peek(5'd27, val);
    check("ill_nowr", val, 32'd0);
    check("err_held2", {31'd0, err}, 32'd1);

    @(negedge clk);
    dbg_addr = 5'd31; disp_sel = 1'b0;
    run(ADD, 5'd31, 5'd2, 5'd5);
    check("disp_old", {16'd0, disp3}, 32'd0);
    check("disp_new", {16'd0, disp4}, 32'd5);

    @(negedge clk);
    op = ADD; rs = 5'd2; rt = 5'd2; rd = 5'd28; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = ADD; rs = 5'd1; rt = 5'd2; rd = 5'd29;
    ndone = 0; at = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (done) begin ndone++; at = k; end
    end
    check("ign_cnt", ndone, 1);
    check("ign_at", at, 3);
    peek(5'd28, val); check("ign_r28", val, 32'd2);
    peek(5'd29, val); check("ign_r29", val, 32'd0);

    @(negedge clk);
    op = ADD; rs = 5'd1; rt = 5'd2; rd = 5'd30; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);
    peek(5'd30, val); check("abort_r30", val, 32'd0);
    peek(5'd1, val); check("abort_r1", val, 32'd0);
    peek(5'd6, val); check("abort_r6", val, 32'd0);

    build();
    @(negedge clk);
    dbg_addr = 5'd6; disp_sel = 1'b1;
    @(negedge clk);
    check("disp_hi", {16'd0, display_output}, 32'h0000_FF00);
    disp_sel = 1'b0;
    @(negedge clk);
    check("disp_lo", {16'd0, display_output}, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
